// File: rtl/fc_out_wr_if.sv
// AXI-Stream style beat channel from fc_out_wr toward the DDR write path.
// Handshake: a beat transfers on a clock edge where tvalid && tready; once tvalid
// is high, tdata/tlast/tvalid hold until that handshake, and tvalid never waits on tready.
interface fc_out_wr_if #(
  parameter int DATA_W = 512
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fc_out_wr.sv
// Buffers the backpressure-free FC result stream in a FIFO and drains it as an
// AXI-Stream master, with almost-full stall, beat-length checking and done/error reporting.
module fc_out_wr #(
  parameter int DATA_W    = 512,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 6,
  parameter int LEN_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [LEN_W-1:0]  n_beats,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  input  logic              in_last,
  output logic              stall,
  fc_out_wr_if.master       m_axis,
  output logic              done,
  output logic              err_ovf,
  output logic              err_len,
  output logic [1:0]        dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              stall_q, stall_d;
  logic              done_q, done_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_len_q, err_len_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              active;
  logic              full;
  logic              tvalid;
  logic              tlast;
  logic              hs;
  logic              wr_en;
  logic [LEN_W-1:0]  len_m1;
  logic [LEN_W-1:0]  in_cnt_p1;

  always_comb begin
    len_m1    = len_q - LEN_W'(1);
    in_cnt_p1 = in_cnt_q + LEN_W'(1);
    active    = (state_q == S_RUN) || (state_q == S_DRAIN);
    full      = (count_q == FULL_LVL);
    tvalid    = active && (count_q != '0);
    tlast     = tvalid && (out_cnt_q == len_m1);
    hs        = tvalid && m_axis.tready;
    // Fullness is judged before the same-cycle pop, so a full FIFO drops even while draining.
    wr_en     = (state_q == S_RUN) && in_vld && !full;
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_ovf_d = err_ovf_q;
    err_len_d = err_len_q;
    done_d    = 1'b0;
    stall_d   = (state_q != S_IDLE) && (count_q >= AF_LVL);

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (hs) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      out_cnt_d = out_cnt_q + LEN_W'(1);
    end
    if (wr_en && !hs) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && hs) begin
      count_d = count_q - CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = n_beats;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          count_d   = '0;
          err_ovf_d = 1'b0;
          err_len_d = 1'b0;
          if (n_beats == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (in_vld) begin
          in_cnt_d = in_cnt_p1;
          if (full) begin
            err_ovf_d = 1'b1;
          end
          // Misplaced in_last is only flagged; the programmed length alone ends the input phase.
          if (in_last != (in_cnt_q == len_m1)) begin
            err_len_d = 1'b1;
          end
          if (in_cnt_p1 == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (in_vld) begin
          err_len_d = 1'b1;
        end
        if (hs && tlast) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      stall_q   <= 1'b0;
      done_q    <= 1'b0;
      err_ovf_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      stall_q   <= stall_d;
      done_q    <= done_d;
      err_ovf_q <= err_ovf_d;
      err_len_q <= err_len_d;
    end
  end

  // Storage carries no reset; validity comes entirely from the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign m_axis.tdata  = mem_q[rd_ptr_q];
  assign m_axis.tvalid = tvalid;
  assign m_axis.tlast  = tlast;
  assign stall         = stall_q;
  assign done          = done_q;
  assign err_ovf       = err_ovf_q;
  assign err_len       = err_len_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fc_out_wr.sv
// Bench for fc_out_wr: table of transfers with a scoreboard on the output stream,
// plus hand-written sequences for backpressure, overflow, zero length and reset.
module tb_fc_out_wr;
  localparam int DATA_W = 512;
  localparam int LEN_W  = 16;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic              clk;
  logic              rstn;
  logic              start;
  logic [LEN_W-1:0]  n_beats;
  logic [DATA_W-1:0] in_data;
  logic              in_vld;
  logic              in_last;
  logic              stall;
  logic              done;
  logic              err_ovf;
  logic              err_len;
  logic [1:0]        dbg_state;

  fc_out_wr_if #(.DATA_W(DATA_W)) axis_if ();

  fc_out_wr #(.DATA_W(DATA_W), .DEPTH(16), .AF_MARGIN(6), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .n_beats   (n_beats),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .in_last   (in_last),
    .stall     (stall),
    .m_axis    (axis_if.master),
    .done      (done),
    .err_ovf   (err_ovf),
    .err_len   (err_len),
    .dbg_state (dbg_state)
  );

  // Each scoreboard entry is {tlast, tdata}.
  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W:0]   mon_e;
  int                checks;
  int                errors;
  int                done_seen;
  logic              rnd_ready;
  logic              prev_hold;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  typedef struct {
    int   n;
    int   last_pos;
    int   extra;
    logic exp_err_len;
  } vec_t;
  vec_t vecs[6];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) axis_if.tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (!(axis_if.tvalid === 1'b1 && axis_if.tdata === prev_data && axis_if.tlast === prev_last)) begin
          errors++;
          $display("FAIL hold_stable actual=v%0b/l%0b/%h required=v1/l%0b/%h",
                   axis_if.tvalid, axis_if.tlast, axis_if.tdata[63:0], prev_last, prev_data[63:0]);
        end
      end
      if (axis_if.tvalid === 1'b1 && axis_if.tready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=%h required=none", axis_if.tdata[63:0]);
        end else begin
          mon_e = exp_q.pop_front();
          if ({axis_if.tlast, axis_if.tdata} !== mon_e) begin
            errors++;
            $display("FAIL out_beat actual=l%0b/%h required=l%0b/%h",
                     axis_if.tlast, axis_if.tdata[63:0], mon_e[DATA_W], mon_e[63:0]);
          end
        end
      end
      prev_hold = (axis_if.tvalid === 1'b1) && (axis_if.tready !== 1'b1);
      prev_data = axis_if.tdata;
      prev_last = axis_if.tlast;
      if (done === 1'b1) done_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] n);
    start   = 1'b1;
    n_beats = n;
    cyc();
    start   = 1'b0;
  endtask

  task automatic drive_beat(input logic [DATA_W-1:0] d, input logic l);
    in_vld  = 1'b1;
    in_data = d;
    in_last = l;
    cyc();
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      cyc();
      k++;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    #1;
    rstn = 1'b1;
    cyc();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(axis_if.tvalid), 64'd0);
    chk({tag, "_tlast"},  64'(axis_if.tlast),  64'd0);
    chk({tag, "_stall"},  64'(stall),   64'd0);
    chk({tag, "_done"},   64'(done),    64'd0);
    chk({tag, "_errovf"}, 64'(err_ovf), 64'd0);
    chk({tag, "_errlen"}, 64'(err_len), 64'd0);
    chk({tag, "_state"},  64'(dbg_state), 64'(S_IDLE));
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [7:0] b);
    return {64{b}};
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [DATA_W-1:0] d;
    int ds;
    checks = 0; errors = 0; done_seen = 0;
    rnd_ready = 1'b0; prev_hold = 1'b0;
    rstn = 1'b0; start = 1'b0; n_beats = '0;
    in_data = '0; in_vld = 1'b0; in_last = 1'b0;
    axis_if.tready = 1'b0;

    vecs[0] = '{n: 4,  last_pos: 4,  extra: 0, exp_err_len: 1'b0};
    vecs[1] = '{n: 3,  last_pos: 2,  extra: 1, exp_err_len: 1'b1};
    vecs[2] = '{n: 1,  last_pos: 1,  extra: 0, exp_err_len: 1'b0};
    vecs[3] = '{n: 16, last_pos: 16, extra: 0, exp_err_len: 1'b0};
    vecs[4] = '{n: 7,  last_pos: 0,  extra: 0, exp_err_len: 1'b1};
    vecs[5] = '{n: 5,  last_pos: 5,  extra: 2, exp_err_len: 1'b1};

    apply_reset();
    chk_idle_outputs("reset");

    // Basic transfer: each beat appears the cycle after it is written.
    axis_if.tready = 1'b1;
    do_start(16'd4);
    for (int i = 1; i <= 4; i++) begin
      d = mk(8'(i * 17));
      exp_q.push_back({(i == 4), d});
      drive_beat(d, (i == 4));
      chk("basic_tvalid", 64'(axis_if.tvalid), 64'd1);
      chk("basic_tdata", axis_if.tdata[63:0], d[63:0]);
      chk("basic_tlast", 64'(axis_if.tlast), 64'(i == 4));
    end
    cyc();
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_errs", {62'd0, err_ovf, err_len}, 64'd0);
    cyc();
    chk("basic_done_pulse", 64'(done), 64'd0);
    chk("basic_state", 64'(dbg_state), 64'(S_IDLE));

    // Table of transfers with random downstream readiness.
    for (int v = 0; v < 6; v++) begin
      rnd_ready = 1'b1;
      do_start(16'(vecs[v].n));
      for (int i = 1; i <= vecs[v].n + vecs[v].extra; i++) begin
        d = rnd_data();
        if (i <= vecs[v].n) exp_q.push_back({(i == vecs[v].n), d});
        drive_beat(d, (i == vecs[v].last_pos));
      end
      wait_done($sformatf("vec%0d_done", v));
      chk($sformatf("vec%0d_errlen", v), 64'(err_len), 64'(vecs[v].exp_err_len));
      chk($sformatf("vec%0d_errovf", v), 64'(err_ovf), 64'd0);
      cyc();
      chk($sformatf("vec%0d_done_pulse", v), 64'(done), 64'd0);
      chk($sformatf("vec%0d_drained", v), 64'(exp_q.size()), 64'd0);
      rnd_ready = 1'b0;
      cyc();
    end

    // Backpressure: stall follows occupancy with one cycle of delay.
    axis_if.tready = 1'b0;
    do_start(16'd12);
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back({(k == 12), mk(8'(k))});
      drive_beat(mk(8'(k)), (k == 12));
      chk($sformatf("bp_stall_%0d", k), 64'(stall), 64'(k >= 11));
    end
    repeat (3) cyc();
    chk("bp_head", axis_if.tdata[63:0], 64'h0101010101010101);
    chk("bp_stall_held", 64'(stall), 64'd1);
    axis_if.tready = 1'b1;
    wait_done("bp_done");
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    cyc();
    chk("bp_stall_idle", 64'(stall), 64'd0);

    // Overflow: only the first 16 beats survive and the transfer never completes.
    axis_if.tready = 1'b0;
    ds = done_seen;
    do_start(16'd20);
    for (int k = 1; k <= 20; k++) begin
      if (k <= 16) exp_q.push_back({1'b0, mk(8'(k + 32))});
      drive_beat(mk(8'(k + 32)), (k == 20));
    end
    chk("ovf_errovf", 64'(err_ovf), 64'd1);
    chk("ovf_errlen", 64'(err_len), 64'd0);
    chk("ovf_state", 64'(dbg_state), 64'(S_DRAIN));
    axis_if.tready = 1'b1;
    repeat (25) cyc();
    chk("ovf_drained", 64'(exp_q.size()), 64'd0);
    chk("ovf_stuck", 64'(dbg_state), 64'(S_DRAIN));
    chk("ovf_tvalid", 64'(axis_if.tvalid), 64'd0);
    chk("ovf_no_done", 64'(done_seen), 64'(ds));
    apply_reset();
    chk_idle_outputs("ovf_reset");

    // Zero length: done next cycle, no output.
    do_start(16'd0);
    chk("zl_done", 64'(done), 64'd1);
    chk("zl_tvalid", 64'(axis_if.tvalid), 64'd0);
    chk("zl_state", 64'(dbg_state), 64'(S_IDLE));
    cyc();
    chk("zl_done_pulse", 64'(done), 64'd0);

    // Start during RUN is ignored: the original length of 4 governs.
    do_start(16'd4);
    for (int k = 1; k <= 4; k++) begin
      d = rnd_data();
      exp_q.push_back({(k == 4), d});
      if (k == 3) begin
        start = 1'b1;
        n_beats = 16'd9;
      end
      drive_beat(d, (k == 4));
      start = 1'b0;
    end
    wait_done("rs_done");
    chk("rs_errlen", 64'(err_len), 64'd0);
    chk("rs_drained", 64'(exp_q.size()), 64'd0);
    cyc();
    chk("rs_state", 64'(dbg_state), 64'(S_IDLE));

    // Reset mid-RUN: tvalid drops asynchronously and buffered beats vanish.
    axis_if.tready = 1'b0;
    do_start(16'd8);
    for (int k = 1; k <= 3; k++) drive_beat(mk(8'(k + 64)), 1'b0);
    chk("mr_tvalid_before", 64'(axis_if.tvalid), 64'd1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("mr_tvalid_async", 64'(axis_if.tvalid), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc();
    chk_idle_outputs("mr_after");
    axis_if.tready = 1'b1;
    do_start(16'd2);
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back({(k == 2), mk(8'(k + 96))});
      drive_beat(mk(8'(k + 96)), (k == 2));
    end
    wait_done("mr_done");
    chk("mr_drained", 64'(exp_q.size()), 64'd0);

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_out_wr.md
Name: fc_out_wr

Overview:
- Downstream consumer of the PPU array controller's FC result stream (fc_outs / fc_out_vld / fc_out_last).
- That stream has no backpressure, so this block buffers each DDR-width beat in a FIFO.
- It drains the FIFO as an AXI-Stream master toward the DDR write path.
- It raises an almost-full stall that the FC scheduler uses to throttle issue. It also checks beat count against the programmed length, and reports done and errors.

Parameters:
- DATA_W, 512, beat width in bits; equals DDR AXIS data width (one byte per FC output lane).
- DEPTH, 16, FIFO depth in beats; power of two, >= 4.
- AF_MARGIN, 6, stall asserts when occupancy >= DEPTH-AF_MARGIN; covers PPU pipeline latency.
- LEN_W, 16, width of the beat-count fields.

Ports:
- clk  in  1  single clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches n_beats and begins a transfer
- n_beats  in  LEN_W  expected number of FC output beats for this transfer
- in_data  in  DATA_W  fc_outs from the PPU array controller
- in_vld  in  1  fc_out_vld
- in_last  in  1  fc_out_last
- stall  out  1  registered almost-full indication to the FC scheduler
- m_axis_tdata  out  DATA_W  output beat
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  final beat of the transfer
- done  out  1  one-cycle pulse when the transfer completes
- err_ovf  out  1  sticky: an input beat was dropped because the FIFO was full
- err_len  out  1  sticky: in_last was misplaced, or extra beats arrived

Behaviour:
- Reset (rstn=0, asynchronous):
  - FSM goes to IDLE; FIFO pointers and count are 0; beat counters are 0.
  - stall, m_axis_tvalid, m_axis_tlast, done, err_ovf and err_len are all 0.
  - m_axis_tdata is don't-care.
  - Reset asserted mid-transfer discards all buffered beats.
- FSM states and transitions:
  - IDLE: on start, latch n_beats into len_r, clear in_cnt, out_cnt, err_ovf and err_len.
    - If n_beats=0: pulse done next cycle and stay in IDLE.
    - Otherwise go to RUN.
  - RUN: on each in_vld:
    - If count<DEPTH, write {in_data} into the FIFO and increment in_cnt.
    - Otherwise drop the beat, set err_ovf, and still increment in_cnt.
    - When in_cnt reaches len_r, go to DRAIN.
  - DRAIN: in_vld beats are dropped and set err_len. When the output handshake with m_axis_tlast=1 occurs, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - A start pulse in any state other than IDLE is ignored.
- in_last check (on an accepted input beat):
  - in_last=1 with in_cnt != len_r-1 sets err_len.
  - in_last=0 on beat len_r-1 sets err_len.
  - Neither case alters flow; the length is governed by len_r only.
- FIFO:
  - Registered write. A beat written at cycle t is visible on m_axis_tdata/m_axis_tvalid at t+1 (first-word-fall-through).
  - Write acceptance uses occupancy before the same-cycle read: when full, a beat is dropped even if a read occurs that cycle.
  - Simultaneous read and write when not full leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- Output:
  - m_axis_tvalid = FIFO not empty, in RUN or DRAIN.
  - A handshake is tvalid&&tready; it pops one entry and increments out_cnt.
  - m_axis_tlast = tvalid && (out_cnt == len_r-1).
  - If beats were dropped, the transfer cannot reach out_cnt=len_r. The block stays in DRAIN until reset or the next reset-free recovery by software. err_ovf is the indication.
  - tdata/tvalid/tlast hold stable while tvalid=1 and tready=0.
- stall:
  - Registered: stall(t+1) = (count(t) >= DEPTH-AF_MARGIN).
  - Deasserts in IDLE.
- Error flags: err_ovf and err_len remain set until the next accepted start.

Test Plan:
- Basic transfer: start with n_beats=4, four in_vld beats with data 0x11.., 0x22.., 0x33.., 0x44.., in_last on the 4th, tready=1. Required: the same four beats out, one cycle after each input; tlast on the 4th; done one cycle after the 4th handshake; no errors.
- Backpressure: n_beats=12, tready=0 throughout input. Required: stall rises once occupancy reaches 10 (registered, one cycle later); data held stable; after tready=1, all 12 beats emerge in order with tlast on beat 12.
- Overflow: n_beats=20, tready=0, 20 consecutive input beats. Required: beats 17-20 dropped, err_ovf=1, FSM remains in DRAIN after 16 outputs; reset returns everything to 0.
- Length errors: n_beats=3 with in_last on beat 2, then a 4th beat after beat 3. Required: err_len=1; exactly 3 beats out with tlast on the 3rd; done pulses.
- Zero-length and mid-run control: start with n_beats=0 gives done the next cycle with no output. A start during RUN is ignored. rstn low mid-RUN gives tvalid=0 immediately (asynchronous) and an empty FIFO after release.
